// File: rtl/spm_cfg_seq.sv
// Configuration sequencer for the scratchpad instruction buffer: streams host words in as
// init strobes, replays them as dwell-spaced run strobes, and drives the scratchpad reset on clear.
module spm_cfg_seq #(
   parameter int INST_W = 48,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_valid_i,
   output logic                       cfg_ready_o,
   input  logic [INST_W-1:0]          cfg_inst_i,
   input  logic                       cfg_last_i,
   input  logic                       start_i,
   input  logic [CNT_W-1:0]           dwell_i,
   input  logic                       clear_i,
   output logic                       spm_rst_o,
   output logic                       spm_init_o,
   output logic [INST_W-1:0]          spm_inst_o,
   output logic                       spm_run_o,
   output logic [$clog2(DEPTH+1)-1:0] step_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o
);

   localparam int STEP_W = $clog2(DEPTH+1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_LOADED, S_RUN_PULSE, S_RUN_WAIT, S_DONE, S_CLR
   } state_t;

   state_t              state_q;
   logic [STEP_W-1:0]   n_inst_q;
   logic [STEP_W-1:0]   step_q;
   logic [CNT_W-1:0]    dwell_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                clr_cnt_q;
   logic                spm_rst_q;
   logic                spm_init_q;
   logic [INST_W-1:0]   spm_inst_q;
   logic                spm_run_q;
   logic                done_q;
   logic                err_q;

   logic [STEP_W-1:0]   n_inst_d;
   logic [STEP_W-1:0]   step_d;
   logic                beat;
   logic                pulse_end;

   assign cfg_ready_o = ((state_q == S_IDLE) || (state_q == S_LOAD)) &&
                        (n_inst_q < STEP_W'(DEPTH)) && !clear_i;
   assign beat        = cfg_valid_i && cfg_ready_o;
   assign n_inst_d    = n_inst_q + STEP_W'(1);
   assign step_d      = step_q + STEP_W'(1);

   // A pulse slot ends either straight out of RUN_PULSE (zero dwell) or when the wait count hits D.
   assign pulse_end   = ((state_q == S_RUN_PULSE) && (dwell_q == '0)) ||
                        ((state_q == S_RUN_WAIT)  && (cnt_q == dwell_q));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         n_inst_q   <= '0;
         step_q     <= '0;
         dwell_q    <= '0;
         cnt_q      <= '0;
         clr_cnt_q  <= 1'b0;
         spm_rst_q  <= 1'b1;
         spm_init_q <= 1'b0;
         spm_inst_q <= '0;
         spm_run_q  <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         // NOTE: strobes default low with non-blocking assignments first; a later branch
         // assignment in the same block wins, which yields clean one-cycle pulses.
         spm_init_q <= 1'b0;
         spm_run_q  <= 1'b0;
         done_q     <= 1'b0;
         spm_rst_q  <= 1'b0;

         if (clear_i) begin
            state_q   <= S_CLR;
            clr_cnt_q <= 1'b0;
            spm_rst_q <= 1'b1;
            n_inst_q  <= '0;
            step_q    <= '0;
            err_q     <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_LOAD: begin
                  if (beat) begin
                     spm_init_q <= 1'b1;
                     spm_inst_q <= cfg_inst_i;
                     n_inst_q   <= n_inst_d;
                     if (cfg_last_i) begin
                        state_q <= S_LOADED;
                     end else if (n_inst_d == STEP_W'(DEPTH)) begin
                        state_q <= S_LOADED;
                        err_q   <= 1'b1;
                     end else begin
                        state_q <= S_LOAD;
                     end
                  end
               end
               S_LOADED: begin
                  if (start_i) begin
                     dwell_q   <= dwell_i;
                     state_q   <= S_RUN_PULSE;
                     spm_run_q <= 1'b1;
                     step_q    <= step_d;
                  end
               end
               S_RUN_PULSE, S_RUN_WAIT: begin
                  if (pulse_end) begin
                     if (step_q == n_inst_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q   <= S_RUN_PULSE;
                        spm_run_q <= 1'b1;
                        step_q    <= step_d;
                     end
                  end else if (state_q == S_RUN_PULSE) begin
                     state_q <= S_RUN_WAIT;
                     cnt_q   <= CNT_W'(1);
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               S_DONE: begin
                  state_q <= S_DONE;
               end
               S_CLR: begin
                  // Scratchpad reset spans the two CLR cycles after clear_i drops.
                  if (clr_cnt_q) begin
                     state_q <= S_IDLE;
                  end else begin
                     clr_cnt_q <= 1'b1;
                     spm_rst_q <= 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign spm_rst_o  = spm_rst_q;
   assign spm_init_o = spm_init_q;
   assign spm_inst_o = spm_inst_q;
   assign spm_run_o  = spm_run_q;
   assign step_o     = step_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign busy_o     = (state_q == S_RUN_PULSE) || (state_q == S_RUN_WAIT) || (state_q == S_CLR);

endmodule
